// File: rtl/limb_wb_bridge.sv
// LIMB (EC byte bus) to Wishbone master bridge, single clock.
// Configurable address/data widths, block autoincrement, bus-error and timeout reporting.
module limb_wb_bridge #(
    parameter int ADDR_BYTES = 5,
    parameter int AW         = 36,
    parameter int DATA_BYTES = 4,
    parameter int TIMEOUT    = 255,
    parameter int AUTOINC    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              limb_d_in,
    output logic [7:0]              limb_d_out,
    output logic                    limb_d_oe,
    input  logic                    limb_stb,
    input  logic                    limb_start,
    input  logic                    limb_nrd,
    output logic                    limb_nwait,
    output logic [AW-1:0]           wb_adr_o,
    output logic [8*DATA_BYTES-1:0] wb_dat_o,
    input  logic [8*DATA_BYTES-1:0] wb_dat_i,
    output logic [DATA_BYTES-1:0]   wb_sel_o,
    output logic                    wb_we_o,
    output logic                    wb_stb_o,
    output logic                    wb_cyc_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    output logic                    err_o,
    input  logic                    err_clr
);
    localparam int MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CW   = $clog2(MAXB + 1);
    localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int ABW  = 8 * ADDR_BYTES;
    localparam int DW   = 8 * DATA_BYTES;

    typedef enum logic [2:0] {IDLE, ADDR, WDATA, WBUS, RDATA, RBUS} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [ABW-1:0]  abuf, abuf_n;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat;
    logic [TW-1:0]   tcnt;
    logic            cyc_q, we_q, err_q;
    logic            ld_adr, ld_wbyte, launch, launch_we, cap, inc;
    logic            start, stb_ok, tmo, resp, bad;
    logic [7:0]      rd_byte;

    // The bus cycle lives in cyc_q, independent of the FSM, so a restart
    // can move the FSM on while the in-flight cycle finishes.
    assign start  = limb_stb & limb_start;
    assign stb_ok = limb_stb & ~cyc_q;
    assign tmo    = cyc_q && (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    assign resp   = cyc_q & (wb_ack_i | wb_err_i | tmo);
    assign bad    = cyc_q & (wb_err_i | tmo);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            abuf  <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            abuf  <= abuf_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        abuf_n    = abuf;
        ld_adr    = 1'b0;
        ld_wbyte  = 1'b0;
        launch    = 1'b0;
        launch_we = 1'b0;
        cap       = 1'b0;
        inc       = 1'b0;
        if (start) begin
            abuf_n      = '0;
            abuf_n[7:0] = limb_d_in;
            cnt_n       = CW'(1);
            state_n     = ADDR;
            if (ADDR_BYTES == 1) begin
                ld_adr = 1'b1;
                cnt_n  = '0;
                if (limb_nrd) begin
                    state_n = WDATA;
                end else begin
                    state_n = RBUS;
                    launch  = 1'b1;
                end
            end
        end else begin
            case (state)
                ADDR: if (stb_ok) begin
                    for (int i = 0; i < ADDR_BYTES; i++)
                        if (cnt == CW'(i)) abuf_n[i*8 +: 8] = limb_d_in;
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(ADDR_BYTES - 1)) begin
                        ld_adr = 1'b1;
                        cnt_n  = '0;
                        if (limb_nrd) begin
                            state_n = WDATA;
                        end else begin
                            state_n = RBUS;
                            launch  = 1'b1;
                        end
                    end
                end
                WDATA: if (stb_ok) begin
                    ld_wbyte = 1'b1;
                    cnt_n    = cnt + CW'(1);
                    if (cnt == CW'(DATA_BYTES - 1)) begin
                        cnt_n     = '0;
                        state_n   = WBUS;
                        launch    = 1'b1;
                        launch_we = 1'b1;
                    end
                end
                WBUS: if (resp) begin
                    state_n = WDATA;
                    inc     = (AUTOINC != 0);
                end
                RBUS: if (resp) begin
                    state_n = RDATA;
                    cap     = 1'b1;
                end
                RDATA: if (stb_ok) begin
                    cnt_n = cnt + CW'(1);
                    if (cnt == CW'(DATA_BYTES - 1)) begin
                        cnt_n   = '0;
                        state_n = RBUS;
                        launch  = 1'b1;
                        inc     = (AUTOINC != 0);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr   <= '0;
            dat   <= '0;
            tcnt  <= '0;
            cyc_q <= 1'b0;
            we_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (ld_adr)
                adr <= abuf_n[AW-1:0];
            else if (inc)
                adr <= adr + AW'(1);

            if (ld_wbyte) begin
                for (int i = 0; i < DATA_BYTES; i++)
                    if (cnt == CW'(i)) dat[i*8 +: 8] <= limb_d_in;
            end else if (cap) begin
                dat <= bad ? '1 : wb_dat_i;
            end

            if (resp) begin
                cyc_q <= 1'b0;
                we_q  <= 1'b0;
            end
            if (launch) begin
                cyc_q <= 1'b1;
                we_q  <= launch_we;
            end

            tcnt <= (cyc_q && !resp && !launch) ? tcnt + TW'(1) : '0;

            // A new error outranks a simultaneous clear.
            if (bad)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;
        end
    end

    always_comb begin
        rd_byte = '0;
        for (int i = 0; i < DATA_BYTES; i++)
            if (cnt == CW'(i)) rd_byte = dat[i*8 +: 8];
    end

    assign limb_d_out = (state == RDATA) ? rd_byte : 8'h00;
    assign limb_d_oe  = (state == RDATA) & ~limb_nrd;
    assign limb_nwait = ~cyc_q;
    assign wb_adr_o   = adr;
    assign wb_dat_o   = dat;
    assign wb_sel_o   = '1;
    assign wb_we_o    = we_q;
    assign wb_stb_o   = cyc_q;
    assign wb_cyc_o   = cyc_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_limb_wb_bridge.sv
// Directed bench for limb_wb_bridge: default-width instance (TIMEOUT=8)
// plus a narrow 3-address-byte / 1-data-byte / no-autoinc instance.
module tb_limb_wb_bridge;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  limb_d_in;
    logic        limb_start, limb_nrd, limb_stb, stb2;
    logic        err_clr;
    logic [31:0] wb_dat_i;
    logic        wb_ack_i, wb_err_i, ack2;

    logic [7:0]  limb_d_out;
    logic        limb_d_oe, limb_nwait;
    logic [35:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, err_o;

    logic [7:0]  d_out2, dato2;
    logic        oe2, nwait2, we2, stbo2, cyc2, erro2;
    logic [19:0] adr2;
    logic [0:0]  sel2;

    int nchk = 0;
    int nfail = 0;
    int ncyc = 0;
    logic cyc_prev = 1'b0;

    always #5 clk = ~clk;

    limb_wb_bridge #(.ADDR_BYTES(5), .AW(36), .DATA_BYTES(4), .TIMEOUT(8), .AUTOINC(1)) dut (
        .clk(clk), .rst(rst),
        .limb_d_in(limb_d_in), .limb_d_out(limb_d_out), .limb_d_oe(limb_d_oe),
        .limb_stb(limb_stb), .limb_start(limb_start), .limb_nrd(limb_nrd), .limb_nwait(limb_nwait),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_sel_o(wb_sel_o),
        .wb_we_o(wb_we_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
        .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .err_o(err_o), .err_clr(err_clr)
    );

    limb_wb_bridge #(.ADDR_BYTES(3), .AW(20), .DATA_BYTES(1), .TIMEOUT(255), .AUTOINC(0)) dut2 (
        .clk(clk), .rst(rst),
        .limb_d_in(limb_d_in), .limb_d_out(d_out2), .limb_d_oe(oe2),
        .limb_stb(stb2), .limb_start(limb_start), .limb_nrd(limb_nrd), .limb_nwait(nwait2),
        .wb_adr_o(adr2), .wb_dat_o(dato2), .wb_dat_i(8'h00), .wb_sel_o(sel2),
        .wb_we_o(we2), .wb_stb_o(stbo2), .wb_cyc_o(cyc2),
        .wb_ack_i(ack2), .wb_err_i(1'b0), .err_o(erro2), .err_clr(1'b0)
    );

    // Count Wishbone cycle starts on the main instance.
    always @(negedge clk) begin
        if (wb_cyc_o && !cyc_prev) ncyc++;
        cyc_prev = wb_cyc_o;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        limb_d_in = 8'h00; limb_start = 1'b0; limb_nrd = 1'b1; limb_stb = 1'b0; stb2 = 1'b0;
        err_clr = 1'b0; wb_dat_i = 32'h0; wb_ack_i = 1'b0; wb_err_i = 1'b0; ack2 = 1'b0;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic send(input bit to2, input logic [7:0] d, input bit st, input bit nrd);
        limb_d_in = d; limb_start = st; limb_nrd = nrd;
        if (to2) stb2 = 1'b1; else limb_stb = 1'b1;
        tick;
        limb_stb = 1'b0; stb2 = 1'b0; limb_start = 1'b0;
    endtask

    task automatic send_addr(input bit to2, input logic [39:0] a, input int nb, input bit nrd);
        send(to2, a[7:0], 1'b1, nrd);
        for (int i = 1; i < nb; i++) send(to2, a[i*8 +: 8], 1'b0, nrd);
    endtask

    task automatic test_reset;
        do_reset;
        nchk++; if (wb_cyc_o !== 1'b0) begin nfail++; $display("FAIL reset_cyc: got %b want 0", wb_cyc_o); end
        nchk++; if (limb_nwait !== 1'b1) begin nfail++; $display("FAIL reset_nwait: got %b want 1", limb_nwait); end
        nchk++; if (wb_sel_o !== 4'hF) begin nfail++; $display("FAIL reset_sel: got %h want F", wb_sel_o); end
        nchk++; if (err_o !== 1'b0) begin nfail++; $display("FAIL reset_err: got %b want 0", err_o); end
        nchk++; if (limb_d_oe !== 1'b0) begin nfail++; $display("FAIL reset_oe: got %b want 0", limb_d_oe); end
        nchk++; if (wb_adr_o !== 36'h0 || wb_dat_o !== 32'h0 || wb_we_o !== 1'b0 || limb_d_out !== 8'h00)
            begin nfail++; $display("FAIL reset_regs: adr %h dat %h we %b dout %h want zeros", wb_adr_o, wb_dat_o, wb_we_o, limb_d_out); end
        nchk++; if (cyc2 !== 1'b0 || nwait2 !== 1'b1 || sel2 !== 1'b1)
            begin nfail++; $display("FAIL reset_dut2: cyc %b nwait %b sel %b want 0 1 1", cyc2, nwait2, sel2); end
    endtask

    task automatic test_write;
        logic [7:0] wd [4] = '{8'h78, 8'h56, 8'h34, 8'h12};
        int nlow = 0;
        int n0;
        do_reset;
        n0 = ncyc;
        send_addr(1'b0, 40'h00_0000_0010, 5, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, wd[i], 1'b0, 1'b1);
        nchk++; if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== 1'b1)
            begin nfail++; $display("FAIL write_ctl: cyc %b stb %b we %b want 1 1 1", wb_cyc_o, wb_stb_o, wb_we_o); end
        nchk++; if (wb_adr_o !== 36'h000000010) begin nfail++; $display("FAIL write_adr: got %h want 000000010", wb_adr_o); end
        nchk++; if (wb_dat_o !== 32'h12345678) begin nfail++; $display("FAIL write_dat: got %h want 12345678", wb_dat_o); end
        nchk++; if (wb_sel_o !== 4'hF) begin nfail++; $display("FAIL write_sel: got %h want F", wb_sel_o); end
        for (int i = 0; i < 4; i++) begin
            if (!limb_nwait) nlow++;
            if (i == 3) wb_ack_i = 1'b1;
            tick;
        end
        wb_ack_i = 1'b0;
        nchk++; if (nlow != 4) begin nfail++; $display("FAIL write_nwait_low: got %0d cycles want 4", nlow); end
        nchk++; if (wb_cyc_o !== 1'b0 || limb_nwait !== 1'b1 || wb_we_o !== 1'b0)
            begin nfail++; $display("FAIL write_end: cyc %b nwait %b we %b want 0 1 0", wb_cyc_o, limb_nwait, wb_we_o); end
        nchk++; if (wb_adr_o !== 36'h000000011) begin nfail++; $display("FAIL write_autoinc: got %h want 000000011", wb_adr_o); end
        tick;
        nchk++; if (ncyc - n0 != 1) begin nfail++; $display("FAIL write_count: got %0d cycles want 1", ncyc - n0); end
    endtask

    task automatic test_block_read;
        logic [7:0]  exp_b [8] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h04, 8'h03, 8'h02, 8'h01};
        logic [35:0] exp_a [2] = '{36'h000000000, 36'h000000001};
        do_reset;
        send_addr(1'b0, 40'hFF_FFFF_FFFF, 5, 1'b0);
        nchk++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b0 || limb_nwait !== 1'b0)
            begin nfail++; $display("FAIL read_ctl: cyc %b we %b nwait %b want 1 0 0", wb_cyc_o, wb_we_o, limb_nwait); end
        nchk++; if (wb_adr_o !== 36'hFFFFFFFFF) begin nfail++; $display("FAIL read_adr: got %h want FFFFFFFFF", wb_adr_o); end
        wb_dat_i = 32'hAABBCCDD; wb_ack_i = 1'b1;
        tick;
        wb_ack_i = 1'b0;
        nchk++; if (limb_nwait !== 1'b1 || wb_cyc_o !== 1'b0 || limb_d_oe !== 1'b1)
            begin nfail++; $display("FAIL read_resp: nwait %b cyc %b oe %b want 1 0 1", limb_nwait, wb_cyc_o, limb_d_oe); end
        for (int w = 0; w < 2; w++) begin
            for (int b = 0; b < 4; b++) begin
                nchk++; if (limb_d_out !== exp_b[w*4+b])
                    begin nfail++; $display("FAIL read_byte%0d: got %h want %h", w*4+b, limb_d_out, exp_b[w*4+b]); end
                send(1'b0, 8'h00, 1'b0, 1'b0);
            end
            nchk++; if (wb_cyc_o !== 1'b1 || wb_adr_o !== exp_a[w])
                begin nfail++; $display("FAIL read_prefetch%0d: cyc %b adr %h want 1 %h", w, wb_cyc_o, wb_adr_o, exp_a[w]); end
            if (w == 0) begin
                wb_dat_i = 32'h01020304; wb_ack_i = 1'b1;
                tick;
                wb_ack_i = 1'b0;
            end
        end
    endtask

    task automatic test_read_err;
        do_reset;
        send_addr(1'b0, 40'h00_0000_0100, 5, 1'b0);
        wb_dat_i = 32'h12345678; wb_err_i = 1'b1;
        tick;
        wb_err_i = 1'b0;
        nchk++; if (err_o !== 1'b1 || wb_cyc_o !== 1'b0)
            begin nfail++; $display("FAIL rerr_flag: err %b cyc %b want 1 0", err_o, wb_cyc_o); end
        for (int b = 0; b < 4; b++) begin
            nchk++; if (limb_d_out !== 8'hFF) begin nfail++; $display("FAIL rerr_byte%0d: got %h want FF", b, limb_d_out); end
            send(1'b0, 8'h00, 1'b0, 1'b0);
        end
        nchk++; if (err_o !== 1'b1 || wb_cyc_o !== 1'b1)
            begin nfail++; $display("FAIL rerr_sticky: err %b cyc %b want 1 1", err_o, wb_cyc_o); end
        err_clr = 1'b1;
        tick;
        err_clr = 1'b0;
        nchk++; if (err_o !== 1'b0) begin nfail++; $display("FAIL rerr_clear: got %b want 0", err_o); end
        err_clr = 1'b1; wb_err_i = 1'b1;
        tick;
        err_clr = 1'b0; wb_err_i = 1'b0;
        nchk++; if (err_o !== 1'b1) begin nfail++; $display("FAIL rerr_set_wins: got %b want 1", err_o); end
    endtask

    task automatic test_timeout;
        logic [7:0] wd [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        int n = 0;
        do_reset;
        send_addr(1'b0, 40'h00_0000_0020, 5, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, wd[i], 1'b0, 1'b1);
        while (wb_cyc_o && n < 50) begin
            n++;
            tick;
        end
        nchk++; if (n != 8) begin nfail++; $display("FAIL tmo_len: got %0d cycles want 8", n); end
        nchk++; if (wb_cyc_o !== 1'b0 || limb_nwait !== 1'b1 || err_o !== 1'b1)
            begin nfail++; $display("FAIL tmo_end: cyc %b nwait %b err %b want 0 1 1", wb_cyc_o, limb_nwait, err_o); end
        nchk++; if (wb_adr_o !== 36'h000000021) begin nfail++; $display("FAIL tmo_autoinc: got %h want 000000021", wb_adr_o); end
    endtask

    task automatic test_restart;
        logic [7:0] wd [4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
        int n0;
        do_reset;
        n0 = ncyc;
        send_addr(1'b0, 40'h00_0000_0040, 5, 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, wd[i], 1'b0, 1'b1);
        send(1'b0, 8'h80, 1'b1, 1'b1);
        nchk++; if (wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 || limb_nwait !== 1'b0)
            begin nfail++; $display("FAIL rst_inflight: cyc %b we %b nwait %b want 1 1 0", wb_cyc_o, wb_we_o, limb_nwait); end
        nchk++; if (wb_adr_o !== 36'h000000040 || wb_dat_o !== 32'hCAFEF00D)
            begin nfail++; $display("FAIL rst_hold: adr %h dat %h want 000000040 CAFEF00D", wb_adr_o, wb_dat_o); end
        wb_ack_i = 1'b1;
        tick;
        wb_ack_i = 1'b0;
        nchk++; if (wb_cyc_o !== 1'b0 || limb_nwait !== 1'b1)
            begin nfail++; $display("FAIL rst_done: cyc %b nwait %b want 0 1", wb_cyc_o, limb_nwait); end
        for (int i = 0; i < 4; i++) send(1'b0, 8'h00, 1'b0, 1'b1);
        tick; tick; tick;
        nchk++; if (wb_adr_o !== 36'h000000080 || wb_cyc_o !== 1'b0)
            begin nfail++; $display("FAIL rst_newaddr: adr %h cyc %b want 000000080 0", wb_adr_o, wb_cyc_o); end
        nchk++; if (ncyc - n0 != 1) begin nfail++; $display("FAIL rst_count: got %0d cycles want 1", ncyc - n0); end
    endtask

    task automatic test_sweep;
        logic [7:0] wd [3] = '{8'hA1, 8'hB2, 8'hC3};
        do_reset;
        send_addr(1'b1, 40'h00_00F1_2345, 3, 1'b1);
        for (int k = 0; k < 3; k++) begin
            send(1'b1, wd[k], 1'b0, 1'b1);
            nchk++; if (cyc2 !== 1'b1 || we2 !== 1'b1 || nwait2 !== 1'b0)
                begin nfail++; $display("FAIL sweep_ctl%0d: cyc %b we %b nwait %b want 1 1 0", k, cyc2, we2, nwait2); end
            nchk++; if (adr2 !== 20'h12345) begin nfail++; $display("FAIL sweep_adr%0d: got %h want 12345", k, adr2); end
            nchk++; if (dato2 !== wd[k]) begin nfail++; $display("FAIL sweep_dat%0d: got %h want %h", k, dato2, wd[k]); end
            ack2 = 1'b1;
            tick;
            ack2 = 1'b0;
            nchk++; if (cyc2 !== 1'b0 || nwait2 !== 1'b1)
                begin nfail++; $display("FAIL sweep_end%0d: cyc %b nwait %b want 0 1", k, cyc2, nwait2); end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_block_read;
        test_read_err;
        test_timeout;
        test_restart;
        test_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
